// File: rtl/wb_dec_pkg.sv
// wb_dec_pkg: shared types and constants for the N-slave Wishbone decoder.
// Holds the FSM state encoding, the error-cause codes and a clog2 helper
// that is usable in parameter expressions.
package wb_dec_pkg;

   // Decoder FSM states (2-bit encoding, also visible on dbg_state_o)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } state_t;

   // Error causes reported by the optional capture registers
   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_UNMAPPED = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   // Ceiling log2; clog2(1) = 0
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: saturating watchdog counter for the decoder BUSY phase.
// i_clr has priority over i_en. o_expired flags the last allowed cycle
// (count == TIMEOUT-1) so the FSM can leave on the same edge.
module wb_timeout_cnt
   import wb_dec_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

   logic [CW-1:0] r_cnt;

   // Count enabled cycles; stop at TIMEOUT instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != SAT)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/wb_decoder_n.sv
// wb_decoder_n: single-master, NS-slave Wishbone classic interconnect.
// The top DEC_W address bits select a slave by tag (lowest index wins on
// overlap); the chosen index is latched for the whole transfer. Unmapped
// addresses and slaves that stay silent for TIMEOUT BUSY cycles get a
// one-cycle m_err_o.
// Optional build macro: WB_DEC_ERR_CAPTURE_EN adds err_adr_o/err_code_o.
//
// Handshake: a request is m_cyc_i & m_stb_i held by the master until it
// sees m_ack_o or m_err_o (never both); the selected slave completes with
// s_ack_i[idx], which is passed straight through while m_stb_i is high.
module wb_decoder_n
   import wb_dec_pkg::*;
#(
   parameter int               NS      = 4,
   parameter int               AW      = 32,
   parameter int               DW      = 32,
   parameter int               SW      = 4,
   parameter int               DEC_W   = 4,
   parameter logic [NS*DEC_W-1:0] BASE = {4'h3, 4'h2, 4'h1, 4'h0},
   parameter int               TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    m_adr_i,
   input  logic [DW-1:0]    m_dat_i,
   output logic [DW-1:0]    m_dat_o,
   input  logic             m_we_i,
   input  logic [SW-1:0]    m_sel_i,
   input  logic             m_stb_i,
   input  logic             m_cyc_i,
   output logic             m_ack_o,
   output logic             m_err_o,
   output logic [AW-1:0]    s_adr_o,
   output logic [DW-1:0]    s_dat_o,
   output logic             s_we_o,
   output logic [SW-1:0]    s_sel_o,
   input  logic [NS*DW-1:0] s_dat_i,
   input  logic [NS-1:0]    s_ack_i,
   output logic [NS-1:0]    s_stb_o,
   output logic [NS-1:0]    s_cyc_o,
`ifdef WB_DEC_ERR_CAPTURE_EN
   output logic [AW-1:0]    err_adr_o,
   output logic [1:0]       err_code_o,
`endif
   output logic [1:0]       dbg_state_o
);

   localparam int IW = (NS > 1) ? clog2(NS) : 1;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_idx;
   logic [IW-1:0] w_dec_idx;
   logic          w_hit;
   logic          w_req;
   logic          w_ack;
   logic          w_expired;

   // Request/address path is shared by all slaves
   assign s_adr_o = m_adr_i;
   assign s_dat_o = m_dat_i;
   assign s_we_o  = m_we_i;
   assign s_sel_o = m_sel_i;

   assign w_req       = m_cyc_i & m_stb_i;
   assign w_ack       = s_ack_i[r_idx] & m_stb_i;
   assign dbg_state_o = r_state;

   // Tag match; scanning downward lets the lowest matching slave win
   always_comb begin
      w_hit     = 1'b0;
      w_dec_idx = '0;
      for (int k = NS - 1; k >= 0; k--) begin
         if (m_adr_i[AW-1 -: DEC_W] == BASE[k*DEC_W +: DEC_W]) begin
            w_hit     = 1'b1;
            w_dec_idx = IW'(k);
         end
      end
   end

   // Watchdog runs only while BUSY and no ack is seen
   wb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (r_state != BUSY),
      .i_en      ((r_state == BUSY) && !w_ack),
      .o_expired (w_expired)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Latch the decoded slave when a mapped request is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
      end else if ((r_state == IDLE) && w_req && w_hit) begin
         r_idx <= w_dec_idx;
      end
   end

   // Next state and all master/slave handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      s_stb_o     = '0;
      s_cyc_o     = '0;
      m_ack_o     = 1'b0;
      m_err_o     = 1'b0;
      m_dat_o     = '0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_state_nxt = w_hit ? BUSY : ERR;
            end
         end
         BUSY: begin
            s_cyc_o[r_idx] = m_cyc_i;
            s_stb_o[r_idx] = m_stb_i;
            m_dat_o        = s_dat_i[r_idx*DW +: DW];
            m_ack_o        = w_ack;
            // Abort beats ack, and ack beats a simultaneous timeout
            if (!m_cyc_i) begin
               w_state_nxt = IDLE;
            end else if (w_ack) begin
               w_state_nxt = IDLE;
            end else if (w_expired) begin
               w_state_nxt = ERR;
            end
         end
         ERR: begin
            m_err_o     = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

`ifdef WB_DEC_ERR_CAPTURE_EN
   logic [AW-1:0] r_err_adr;
   logic [1:0]    r_err_code;

   // Record address and cause on every entry to ERR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_adr  <= '0;
         r_err_code <= ERR_NONE;
      end else if ((w_state_nxt == ERR) && (r_state != ERR)) begin
         r_err_adr  <= m_adr_i;
         r_err_code <= (r_state == BUSY) ? ERR_TIMEOUT : ERR_UNMAPPED;
      end
   end

   assign err_adr_o  = r_err_adr;
   assign err_code_o = r_err_code;
`endif

endmodule

// File: tb/tb_wb_decoder_n.sv
// tb_wb_decoder_n: bench for wb_decoder_n. Two instances share the master
// and slave-side stimulus: dut_a uses the default tags with TIMEOUT=8,
// dut_b uses overlapping tags (slaves 0 and 1 both 4'h0) with TIMEOUT=4.
// Each stimulus cycle pushes the expected output word for one instance;
// the negedge monitor pops and compares it.
module tb_wb_decoder_n;
   import wb_dec_pkg::*;

   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int OW = 2 + NS + NS + 2 + DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic [AW-1:0]    m_adr_i = '0;
   logic [DW-1:0]    m_dat_i = '0;
   logic             m_we_i  = 1'b0;
   logic [SW-1:0]    m_sel_i = '0;
   logic             m_stb_i = 1'b0;
   logic             m_cyc_i = 1'b0;
   logic [NS*DW-1:0] s_dat_i = '0;
   logic [NS-1:0]    s_ack_i = '0;
   bit               hold_dat = 1'b0;

   // ---------------- per-instance outputs ----------------
   logic [DW-1:0] a_dat, b_dat;
   logic          a_ack, b_ack, a_err, b_err;
   logic [AW-1:0] a_sadr, b_sadr;
   logic [DW-1:0] a_sdat, b_sdat;
   logic          a_swe, b_swe;
   logic [SW-1:0] a_ssel, b_ssel;
   logic [NS-1:0] a_stb, b_stb, a_cyc, b_cyc;
   logic [1:0]    a_dbg, b_dbg;
`ifdef WB_DEC_ERR_CAPTURE_EN
   logic [AW-1:0] a_eadr, b_eadr;
   logic [1:0]    a_ecode, b_ecode;
`endif

   wb_decoder_n #(.NS(NS), .AW(AW), .DW(DW), .SW(SW), .DEC_W(4),
                  .BASE(16'h3210), .TIMEOUT(8)) dut_a (
      .clk(clk), .rst(rst),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(a_dat), .m_we_i(m_we_i),
      .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
      .m_ack_o(a_ack), .m_err_o(a_err),
      .s_adr_o(a_sadr), .s_dat_o(a_sdat), .s_we_o(a_swe), .s_sel_o(a_ssel),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_stb_o(a_stb), .s_cyc_o(a_cyc),
`ifdef WB_DEC_ERR_CAPTURE_EN
      .err_adr_o(a_eadr), .err_code_o(a_ecode),
`endif
      .dbg_state_o(a_dbg)
   );

   wb_decoder_n #(.NS(NS), .AW(AW), .DW(DW), .SW(SW), .DEC_W(4),
                  .BASE(16'h3200), .TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(b_dat), .m_we_i(m_we_i),
      .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
      .m_ack_o(b_ack), .m_err_o(b_err),
      .s_adr_o(b_sadr), .s_dat_o(b_sdat), .s_we_o(b_swe), .s_sel_o(b_ssel),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_stb_o(b_stb), .s_cyc_o(b_cyc),
`ifdef WB_DEC_ERR_CAPTURE_EN
      .err_adr_o(b_eadr), .err_code_o(b_ecode),
`endif
      .dbg_state_o(b_dbg)
   );

   logic [OW-1:0] obs_a, obs_b;
   assign obs_a = {a_dbg, a_stb, a_cyc, a_ack, a_err, a_dat};
   assign obs_b = {b_dbg, b_stb, b_cyc, b_ack, b_err, b_dat};

   // ---------------- scoreboard ----------------
   logic [OW-1:0] exp_q[$];
   string         tag_q[$];
   int            dut_q[$];
   int            checks   = 0;
   int            failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [OW-1:0] mon_exp;
   string         mon_tag;
   int            mon_dut;

   // Compare the expected word for this cycle away from the active edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         mon_dut = dut_q.pop_front();
         chk(mon_tag, 64'(mon_dut == 0 ? obs_a : obs_b), 64'(mon_exp));
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1 after inputs are set; records what the chosen
   // instance must show during this cycle, then advances one clock.
   task automatic step(input int dut, input string tag, input state_t st,
                       input int lane, input logic ack, input logic err);
      logic [NS-1:0] strb;
      logic [NS-1:0] cycv;
      logic [DW-1:0] dat;
      if (!hold_dat) begin
         for (int k = 0; k < NS; k++) s_dat_i[k*DW +: DW] = $urandom;
      end
      strb = '0;
      cycv = '0;
      dat  = '0;
      if (st == BUSY) begin
         strb[lane] = m_stb_i;
         cycv[lane] = m_cyc_i;
         dat        = s_dat_i[lane*DW +: DW];
      end
      exp_q.push_back({st, strb, cycv, ack, err, dat});
      tag_q.push_back(tag);
      dut_q.push_back(dut);
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [AW-1:0] adr, input logic we);
      m_adr_i = adr;
      m_we_i  = we;
      m_sel_i = 4'($urandom_range(1, 15));
      m_dat_i = $urandom;
      m_cyc_i = 1'b1;
      m_stb_i = 1'b1;
   endtask

   task automatic drop();
      m_cyc_i = 1'b0;
      m_stb_i = 1'b0;
      s_ack_i = '0;
   endtask

   task automatic gap(input int dut);
      drop();
      step(dut, "gap0", IDLE, 0, 1'b0, 1'b0);
      step(dut, "gap1", IDLE, 0, 1'b0, 1'b0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      @(posedge clk);
      #1;
      // Reset state on both instances
      step(0, "reset_a", IDLE, 0, 1'b0, 1'b0);
      step(1, "reset_b", IDLE, 0, 1'b0, 1'b0);
`ifdef WB_DEC_ERR_CAPTURE_EN
      chk("reset_ecode", 64'(a_ecode), 64'(ERR_NONE));
      chk("reset_eadr", 64'(a_eadr), 64'h0);
`endif
      rst = 1'b0;
      step(0, "idle_a", IDLE, 0, 1'b0, 1'b0);

      // Read slave 2, ack in BUSY cycle 3 with 0xDEADBEEF
      req(32'h2000_0010, 1'b0);
      chk("bcast_adr", 64'(a_sadr), 64'h2000_0010);
      chk("bcast_we_sel", 64'({a_swe, a_ssel}), 64'({1'b0, m_sel_i}));
      chk("bcast_dat", 64'(a_sdat), 64'(m_dat_i));
      step(0, "rd2_req", IDLE, 0, 1'b0, 1'b0);
      step(0, "rd2_busy1", BUSY, 2, 1'b0, 1'b0);
      step(0, "rd2_busy2", BUSY, 2, 1'b0, 1'b0);
      hold_dat = 1'b1;
      s_dat_i[2*DW +: DW] = 32'hDEAD_BEEF;
      s_ack_i = 4'b0100;
      step(0, "rd2_ack", BUSY, 2, 1'b1, 1'b0);
      hold_dat = 1'b0;
      gap(0);

      // Unmapped write: error one cycle after the request
      req(32'h7000_0000, 1'b1);
      step(0, "unm_req", IDLE, 0, 1'b0, 1'b0);
      step(0, "unm_err", ERR, 0, 1'b0, 1'b1);
`ifdef WB_DEC_ERR_CAPTURE_EN
      chk("unm_eadr", 64'(a_eadr), 64'h7000_0000);
      chk("unm_ecode", 64'(a_ecode), 64'(ERR_UNMAPPED));
`endif
      gap(0);

      // Slave 1 never acks: 8 BUSY cycles, then one error cycle
      req(32'h1000_0040, 1'b0);
      step(0, "to_req", IDLE, 0, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) step(0, $sformatf("to_busy%0d", i), BUSY, 1, 1'b0, 1'b0);
      step(0, "to_err", ERR, 0, 1'b0, 1'b1);
`ifdef WB_DEC_ERR_CAPTURE_EN
      chk("to_eadr", 64'(a_eadr), 64'h1000_0040);
      chk("to_ecode", 64'(a_ecode), 64'(ERR_TIMEOUT));
`endif
      gap(0);

      // dut_b (TIMEOUT=4): ack on the expiring BUSY cycle wins
      req(32'h2000_0000, 1'b0);
      step(1, "exp_req", IDLE, 0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) step(1, $sformatf("exp_busy%0d", i), BUSY, 2, 1'b0, 1'b0);
      s_ack_i = 4'b0100;
      step(1, "exp_ack", BUSY, 2, 1'b1, 1'b0);
      drop();
      step(1, "exp_no_err", IDLE, 0, 1'b0, 1'b0);
      gap(1);

      // dut_b overlapping tags: slave 0 wins; then m_cyc_i drops mid-BUSY
      req(32'h0000_0004, 1'b0);
      step(1, "ovl_req", IDLE, 0, 1'b0, 1'b0);
      step(1, "ovl_busy", BUSY, 0, 1'b0, 1'b0);
      m_cyc_i = 1'b0;
      m_stb_i = 1'b0;
      step(1, "abort_busy", BUSY, 0, 1'b0, 1'b0);
      step(1, "abort_idle", IDLE, 0, 1'b0, 1'b0);
      gap(1);

      // Asynchronous reset in the middle of a BUSY cycle
      req(32'h3000_0020, 1'b0);
      step(0, "rst_req", IDLE, 0, 1'b0, 1'b0);
      step(0, "rst_busy", BUSY, 3, 1'b0, 1'b0);
      s_ack_i = 4'b1000;
      #2;
      chk("rst_pre_ack", 64'(a_ack), 64'h1);
      rst = 1'b1;
      #1;
      chk("rst_async_out", 64'({a_stb, a_cyc, a_ack, a_err}), 64'h0);
      chk("rst_async_state", 64'(a_dbg), 64'(IDLE));
      chk("rst_async_dat", 64'(a_dat), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drop();
      step(0, "post_rst_idle", IDLE, 0, 1'b0, 1'b0);
      req(32'h0000_0100, 1'b1);
      step(0, "post_rst_req", IDLE, 0, 1'b0, 1'b0);
      s_ack_i = 4'b0001;
      step(0, "post_rst_ack", BUSY, 0, 1'b1, 1'b0);
      gap(0);

      @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
